// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode/execute hazard bus between ID and the hazard scoreboard
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int FWD_STAGES = 2,
  parameter int CNT_W = 32
);
  localparam int FSEL_W = $clog2(FWD_STAGES + 1);
  logic id_valid_i;
  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic id_use_rs1_i;
  logic id_use_rs2_i;
  logic [REG_AW-1:0] id_rd_i;
  logic id_regwrite_i;
  logic id_memread_i;
  logic redirect_i;
  logic stall_o;
  logic flush_o;
  logic [FSEL_W-1:0] forward_a_o;
  logic [FSEL_W-1:0] forward_b_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
    output id_rd_i, id_regwrite_i, id_memread_i, redirect_i,
    input stall_o, flush_o, forward_a_o, forward_b_o, stall_cnt_o, flush_cnt_o
  );
  modport slave (
    input id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
    input id_rd_i, id_regwrite_i, id_memread_i, redirect_i,
    output stall_o, flush_o, forward_a_o, forward_b_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shift-register scoreboard giving forward selects, load-use stalls, redirect flush and event counters
module hazard_scoreboard #(
  parameter int REG_AW = 5,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT = 1,
  parameter int BRANCH_STAGE = 1,
  parameter int CNT_W = 32
) (
  input logic clk_i,
  input logic reset_i,
  hazard_scoreboard_if.slave bus
);
  localparam int FSEL_W = $clog2(FWD_STAGES + 1);
  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memread;
    logic use_rs1;
    logic use_rs2;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } entry_t;
  entry_t sb [0:FWD_STAGES];
  entry_t id_e;
  logic hazard;
  logic stall;
  logic flush;
  logic issue;
  logic [FSEL_W-1:0] fwd_a;
  logic [FSEL_W-1:0] fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  function automatic logic hit(entry_t e, logic [REG_AW-1:0] s);
    return e.valid && e.regwrite && e.rd == s && e.rd != '0;
  endfunction
  always_comb begin
    id_e = '{valid: bus.id_valid_i, regwrite: bus.id_regwrite_i, memread: bus.id_memread_i,
             use_rs1: bus.id_use_rs1_i, use_rs2: bus.id_use_rs2_i, rd: bus.id_rd_i,
             rs1: bus.id_rs1_i, rs2: bus.id_rs2_i};
    hazard = 1'b0;
    for (int j = 0; j < FWD_STAGES; j++)
      if (j + 1 <= LOAD_LAT && sb[j].memread &&
          ((bus.id_use_rs1_i && hit(sb[j], bus.id_rs1_i)) ||
           (bus.id_use_rs2_i && hit(sb[j], bus.id_rs2_i))))
        hazard = 1'b1;
    stall = hazard && bus.id_valid_i && !bus.redirect_i && !reset_i;
    flush = bus.redirect_i && !reset_i;
    issue = bus.id_valid_i && !stall && !bus.redirect_i;
    fwd_a = '0;
    fwd_b = '0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (sb[0].valid && sb[0].use_rs1 && hit(sb[k], sb[0].rs1) && (!sb[k].memread || k > LOAD_LAT))
        fwd_a = FSEL_W'(k);
      if (sb[0].valid && sb[0].use_rs2 && hit(sb[k], sb[0].rs2) && (!sb[k].memread || k > LOAD_LAT))
        fwd_b = FSEL_W'(k);
    end
    fwd_a = reset_i ? '0 : fwd_a;
    fwd_b = reset_i ? '0 : fwd_b;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k <= FWD_STAGES; k++)
        sb[k] <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      sb[0] <= issue ? id_e : '0;
      for (int k = 1; k <= FWD_STAGES; k++)
        sb[k] <= sb[k-1];
      for (int k = 0; k <= FWD_STAGES; k++)
        if (bus.redirect_i && k < BRANCH_STAGE)
          sb[k].valid <= 1'b0;
      if (stall && !(&stall_cnt))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush && !(&flush_cnt))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
  assign bus.stall_o = stall;
  assign bus.flush_o = flush;
  assign bus.forward_a_o = fwd_a;
  assign bus.forward_b_o = fwd_b;
  assign bus.stall_cnt_o = stall_cnt;
  assign bus.flush_cnt_o = flush_cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: table-driven check of the default and a deep-pipeline hazard scoreboard
module tb_hazard_scoreboard;
  typedef struct {
    int v, rs1, rs2, u1, u2, rd, rw, mr, rdr;
    int st, fl, fa, fb, sc, fc;
  } vec_t;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int tests = 0;
  int fails = 0;
  vec_t ta [17];
  vec_t tv_b [18];
  vec_t tm [3];
  vec_t tr;
  always #5 clk = ~clk;
  hazard_scoreboard_if #(.REG_AW(5), .FWD_STAGES(2), .CNT_W(32)) ba ();
  hazard_scoreboard_if #(.REG_AW(5), .FWD_STAGES(3), .CNT_W(2)) bb ();
  assign bb.id_valid_i = ba.id_valid_i;
  assign bb.id_rs1_i = ba.id_rs1_i;
  assign bb.id_rs2_i = ba.id_rs2_i;
  assign bb.id_use_rs1_i = ba.id_use_rs1_i;
  assign bb.id_use_rs2_i = ba.id_use_rs2_i;
  assign bb.id_rd_i = ba.id_rd_i;
  assign bb.id_regwrite_i = ba.id_regwrite_i;
  assign bb.id_memread_i = ba.id_memread_i;
  assign bb.redirect_i = ba.redirect_i;
  hazard_scoreboard #(.REG_AW(5), .FWD_STAGES(2), .LOAD_LAT(1), .BRANCH_STAGE(1), .CNT_W(32)) dut_a (
    .clk_i(clk), .reset_i(rst_a), .bus(ba.slave)
  );
  hazard_scoreboard #(.REG_AW(5), .FWD_STAGES(3), .LOAD_LAT(2), .BRANCH_STAGE(2), .CNT_W(2)) dut_b (
    .clk_i(clk), .reset_i(rst_b), .bus(bb.slave)
  );
  task automatic chk(input string nm, input bit p, input int idx, input logic [31:0] got, input int exp);
    tests++;
    if (got !== 32'(exp)) begin
      fails++;
      $display("FAIL %s_%s[%0d]: got %0d, expected %0d", p ? "B" : "A", nm, idx, got, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    ba.id_valid_i = 1'(v.v);
    ba.id_rs1_i = 5'(v.rs1);
    ba.id_rs2_i = 5'(v.rs2);
    ba.id_use_rs1_i = 1'(v.u1);
    ba.id_use_rs2_i = 1'(v.u2);
    ba.id_rd_i = 5'(v.rd);
    ba.id_regwrite_i = 1'(v.rw);
    ba.id_memread_i = 1'(v.mr);
    ba.redirect_i = 1'(v.rdr);
  endtask
  task automatic run(input vec_t v, input bit p, input int idx);
    drive(v);
    #4;
    chk("stall", p, idx, p ? 32'(bb.stall_o) : 32'(ba.stall_o), v.st);
    chk("flush", p, idx, p ? 32'(bb.flush_o) : 32'(ba.flush_o), v.fl);
    chk("fwd_a", p, idx, p ? 32'(bb.forward_a_o) : 32'(ba.forward_a_o), v.fa);
    chk("fwd_b", p, idx, p ? 32'(bb.forward_b_o) : 32'(ba.forward_b_o), v.fb);
    chk("stall_cnt", p, idx, p ? 32'(bb.stall_cnt_o) : 32'(ba.stall_cnt_o), v.sc);
    chk("flush_cnt", p, idx, p ? 32'(bb.flush_cnt_o) : 32'(ba.flush_cnt_o), v.fc);
    @(posedge clk);
    #1;
  endtask
  initial begin
    ta[0]  = '{1, 5, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
    ta[1]  = '{1, 1, 2, 1, 1, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0};
    ta[2]  = '{1, 5, 5, 1, 1, 6, 1, 0, 0,   0, 0, 0, 0, 0, 0};
    ta[3]  = '{1, 5, 5, 1, 1, 12, 1, 0, 0,  0, 0, 1, 1, 0, 0};
    ta[4]  = '{1, 1, 0, 1, 0, 7, 1, 1, 0,   0, 0, 2, 2, 0, 0};
    ta[5]  = '{1, 7, 1, 1, 1, 8, 1, 0, 0,   1, 0, 0, 0, 0, 0};
    ta[6]  = '{1, 7, 1, 1, 1, 8, 1, 0, 0,   0, 0, 0, 0, 1, 0};
    ta[7]  = '{1, 1, 0, 1, 0, 0, 1, 1, 0,   0, 0, 2, 0, 1, 0};
    ta[8]  = '{1, 0, 0, 1, 1, 13, 1, 0, 0,  0, 0, 0, 0, 1, 0};
    ta[9]  = '{1, 1, 2, 1, 1, 9, 1, 0, 0,   0, 0, 0, 0, 1, 0};
    ta[10] = '{1, 1, 2, 1, 1, 9, 1, 0, 0,   0, 0, 0, 0, 1, 0};
    ta[11] = '{1, 9, 9, 1, 1, 14, 1, 0, 0,  0, 0, 0, 0, 1, 0};
    ta[12] = '{1, 1, 0, 1, 0, 10, 1, 1, 0,  0, 0, 1, 1, 1, 0};
    ta[13] = '{1, 10, 2, 1, 1, 15, 1, 0, 1, 0, 1, 0, 0, 1, 0};
    ta[14] = '{1, 15, 15, 1, 1, 16, 1, 0, 0, 0, 0, 0, 0, 1, 1};
    ta[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1};
    ta[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1};
    tm[0]  = '{1, 1, 0, 1, 0, 7, 1, 1, 0,   0, 0, 0, 0, 1, 1};
    tm[1]  = '{1, 1, 0, 1, 0, 7, 1, 1, 0,   0, 0, 0, 0, 1, 1};
    tm[2]  = '{1, 7, 1, 1, 1, 8, 1, 0, 0,   0, 0, 0, 0, 0, 0};
    tv_b[0]  = '{1, 1, 0, 1, 0, 3, 1, 1, 0,   0, 0, 0, 0, 0, 0};
    tv_b[1]  = '{1, 3, 0, 1, 1, 4, 1, 0, 0,   1, 0, 0, 0, 0, 0};
    tv_b[2]  = '{1, 3, 0, 1, 1, 4, 1, 0, 0,   1, 0, 0, 0, 1, 0};
    tv_b[3]  = '{1, 3, 0, 1, 1, 4, 1, 0, 0,   0, 0, 0, 0, 2, 0};
    tv_b[4]  = '{1, 1, 0, 1, 0, 3, 1, 1, 0,   0, 0, 3, 0, 2, 0};
    tv_b[5]  = '{1, 3, 0, 1, 1, 4, 1, 0, 0,   1, 0, 0, 0, 2, 0};
    tv_b[6]  = '{1, 3, 0, 1, 1, 4, 1, 0, 0,   1, 0, 0, 0, 3, 0};
    tv_b[7]  = '{1, 3, 0, 1, 1, 4, 1, 0, 0,   0, 0, 0, 0, 3, 0};
    tv_b[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 3, 0, 3, 0};
    tv_b[9]  = '{1, 1, 2, 1, 1, 20, 1, 0, 0,  0, 0, 0, 0, 3, 0};
    tv_b[10] = '{1, 1, 2, 1, 1, 21, 1, 0, 0,  0, 0, 0, 0, 3, 0};
    tv_b[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 3, 0};
    tv_b[12] = '{1, 21, 20, 1, 1, 22, 1, 0, 0, 0, 0, 0, 0, 3, 1};
    tv_b[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3, 3, 1};
    tv_b[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 3, 1};
    tv_b[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 3, 2};
    tv_b[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 3, 3};
    tv_b[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 3};
    tr = '{1, 7, 7, 1, 1, 7, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive(tr);
    @(posedge clk);
    #1;
    run(tr, 1'b0, 100);
    run(tr, 1'b1, 101);
    rst_a = 1'b0;
    foreach (ta[i]) run(ta[i], 1'b0, i);
    run(tm[0], 1'b0, 200);
    rst_a = 1'b1;
    run(tm[1], 1'b0, 201);
    rst_a = 1'b0;
    run(tm[2], 1'b0, 202);
    rst_a = 1'b1;
    rst_b = 1'b0;
    foreach (tv_b[i]) run(tv_b[i], 1'b1, i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
